// File: rtl/fetch_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_mem_arbiter
// Purpose  : Shares one single-outstanding memory between fetch and data stages
//            with bounded-fairness arbitration and fetch flush handling.
// Revision : 1.0
// ============================================================================
module fetch_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MAX_CONSEC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              m_en,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_valid
);

  localparam int c_CNT_W = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
  localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_CONSEC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSY_IF = 3'd1,
    S_BUSY_DM = 3'd2,
    S_DONE_IF = 3'd3,
    S_DONE_DM = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_consec;
  logic               r_cancel;
  logic               r_if_done;

  logic w_if_elig;
  logic w_grant_dm;
  logic w_grant_if;

  assign w_if_elig  = if_req && !if_flush;
  // Data stage wins contention until it has taken MAX_CONSEC grants in a row.
  assign w_grant_dm = dm_req && !(w_if_elig && (r_consec == c_MAX));
  assign w_grant_if = w_if_elig && !w_grant_dm;

  // A flush arriving in the completion cycle still withholds the pulse.
  assign if_ready = r_if_done && !if_flush;
  assign if_stall = if_req && !if_ready;
  assign dm_stall = dm_req && !dm_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_consec  <= '0;
      r_cancel  <= 1'b0;
      r_if_done <= 1'b0;
      dm_ready  <= 1'b0;
      m_en      <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      m_en      <= 1'b0;
      r_if_done <= 1'b0;
      dm_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cancel <= 1'b0;
          if (w_grant_dm) begin
            r_state <= S_BUSY_DM;
            m_en    <= 1'b1;
            m_wr    <= dm_wr;
            m_addr  <= dm_addr;
            m_wdata <= dm_wdata;
            if (w_if_elig)
              r_consec <= (r_consec == c_MAX) ? r_consec : r_consec + c_CNT_W'(1);
            else
              r_consec <= '0;
          end else if (w_grant_if) begin
            r_state  <= S_BUSY_IF;
            m_en     <= 1'b1;
            m_wr     <= 1'b0;
            m_addr   <= if_addr;
            m_wdata  <= '0;
            r_consec <= '0;
          end
        end
        S_BUSY_IF: begin
          if (if_flush) r_cancel <= 1'b1;
          if (m_valid) begin
            if (r_cancel || if_flush) begin
              r_state <= S_IDLE;
            end else begin
              if_rdata  <= m_rdata;
              r_if_done <= 1'b1;
              r_state   <= S_DONE_IF;
            end
          end
        end
        S_BUSY_DM: begin
          if (m_valid) begin
            if (!m_wr) dm_rdata <= m_rdata;
            dm_ready <= 1'b1;
            r_state  <= S_DONE_DM;
          end
        end
        S_DONE_IF: r_state <= S_IDLE;
        S_DONE_DM: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
